// File: rtl/run_ctrl.sv
// Launch/wait/kill run controller with bounded retry and registered status pulses.
// Define RUN_CTRL_STATS_EN to build the saturating ok/fail run counters.
module run_ctrl #(
  parameter int TIMEOUT     = 128,
  parameter int MAX_RETRY   = 1,
  parameter int KILL_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort_req,
  input  logic       done_in,
  output logic       go,
  output logic       kill,
  output logic       busy,
  output logic       run_ok,
  output logic       run_fail,
  output logic [1:0] attempt,
  output logic [7:0] ok_count,
  output logic [7:0] fail_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_KILL
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] KILL_LAST  = 4'(KILL_CYCLES - 1);
  localparam logic [1:0] RETRY_LAST = 2'(MAX_RETRY);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] kcnt_q, kcnt_d;
  logic       abort_q, abort_d;
  logic [1:0] attempt_d;
  logic       ok_evt, fail_evt;
  logic       go_d, kill_d, busy_d;

  // Outputs are registered from the next-state decode so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      kcnt_q   <= '0;
      abort_q  <= 1'b0;
      attempt  <= '0;
      go       <= 1'b0;
      kill     <= 1'b0;
      busy     <= 1'b0;
      run_ok   <= 1'b0;
      run_fail <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      kcnt_q   <= kcnt_d;
      abort_q  <= abort_d;
      attempt  <= attempt_d;
      go       <= go_d;
      kill     <= kill_d;
      busy     <= busy_d;
      run_ok   <= ok_evt;
      run_fail <= fail_evt;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    kcnt_d    = kcnt_q;
    abort_d   = abort_q;
    attempt_d = attempt;
    ok_evt    = 1'b0;
    fail_evt  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LAUNCH;
          attempt_d = '0;
          abort_d   = 1'b0;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        timer_d = timer_q + 8'd1;
        if (done_in) begin
          state_d = S_IDLE;
          ok_evt  = 1'b1;
        end else if (abort_req) begin
          state_d = S_KILL;
          abort_d = 1'b1;
          kcnt_d  = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d = S_KILL;
          abort_d = 1'b0;
          kcnt_d  = '0;
        end
      end
      S_KILL: begin
        if (kcnt_q == KILL_LAST) begin
          if (abort_q || attempt == RETRY_LAST) begin
            state_d  = S_IDLE;
            fail_evt = 1'b1;
          end else begin
            state_d   = S_LAUNCH;
            attempt_d = attempt + 2'd1;
          end
        end else begin
          kcnt_d = kcnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    go_d   = (state_d == S_LAUNCH);
    kill_d = (state_d == S_KILL);
    busy_d = (state_d != S_IDLE);
  end

`ifdef RUN_CTRL_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ok_count   <= '0;
      fail_count <= '0;
    end else begin
      if (ok_evt && ok_count != 8'hFF)
        ok_count <= ok_count + 8'd1;
      if (fail_evt && fail_count != 8'hFF)
        fail_count <= fail_count + 8'd1;
    end
  end
`else
  assign ok_count   = '0;
  assign fail_count = '0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: stimulus queues expected run results, a monitor pops on each result pulse.
module tb_run_ctrl;

  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort_req = 1'b0;
  logic       done_in = 1'b0;
  logic       go, kill, busy, run_ok, run_fail;
  logic [1:0] attempt;
  logic [7:0] ok_count, fail_count;

  typedef struct {
    bit         ok;
    logic [1:0] att;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int go_cyc = 0;
  int kill_cyc = 0;
  int busy_cyc = 0;

  run_ctrl #(.TIMEOUT(TO), .MAX_RETRY(1), .KILL_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort_req(abort_req), .done_in(done_in),
    .go(go), .kill(kill), .busy(busy), .run_ok(run_ok), .run_fail(run_fail),
    .attempt(attempt), .ok_count(ok_count), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: observes result pulses and tallies go/kill/busy cycles.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      go_cyc   += int'(go);
      kill_cyc += int'(kill);
      busy_cyc += int'(busy);
      chk("go_kill_exclusive", int'(go & kill), 0);
      if (run_ok || run_fail) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", int'({run_ok, run_fail}), 0);
        end else begin
          e = sb.pop_front();
          chk("result_kind", int'({run_ok, run_fail}), e.ok ? 2 : 1);
          chk("result_attempt", int'(attempt), int'(e.att));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_result(input bit ok, input logic [1:0] att);
    exp_t e;
    e.ok  = ok;
    e.att = att;
    sb.push_back(e);
  endtask

  // Leaves the DUT in WAIT with timer==0.
  task automatic launch();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    @(negedge clk);
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({name, "_idle_timeout"}, 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic ok_run(input int k);
    expect_result(1'b1, 2'd0);
    launch();
    tick(k);
    done_in = 1'b1;
    tick(1);
    done_in = 1'b0;
  endtask

  int g0, k0, b0, n;
  int exp_ok, exp_fail;

  initial begin
    tick(3);
    chk("rst_go", int'(go), 0);
    chk("rst_kill", int'(kill), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_attempt", int'(attempt), 0);
    chk("rst_counts", int'({ok_count, fail_count}), 0);
    reset = 1'b0;
    tick(2);

    // Success: done_in 5 cycles into WAIT.
    g0 = go_cyc; k0 = kill_cyc; b0 = busy_cyc;
    ok_run(5);
    wait_idle("ok5", 50);
    chk("ok5_go", go_cyc - g0, 1);
    chk("ok5_kill", kill_cyc - k0, 0);
    chk("ok5_busy_cycles", busy_cyc - b0, 1 + 6);
    chk("ok5_busy_low", int'(busy), 0);

    // Done on the last WAIT cycle beats the timeout.
    g0 = go_cyc; k0 = kill_cyc;
    ok_run(TO - 1);
    wait_idle("ok_last", 50);
    chk("ok_last_go", go_cyc - g0, 1);
    chk("ok_last_kill", kill_cyc - k0, 0);

    // Timeout twice: two launches, four kill cycles, fail with attempt 1.
    g0 = go_cyc; k0 = kill_cyc; b0 = busy_cyc;
    expect_result(1'b0, 2'd1);
    launch();
    wait_idle("timeout", 100);
    chk("timeout_go", go_cyc - g0, 2);
    chk("timeout_kill", kill_cyc - k0, 4);
    chk("timeout_busy_cycles", busy_cyc - b0, 2 * (1 + TO + 2));
    tick(3);
    chk("attempt_hold", int'(attempt), 1);

    // Abort at WAIT cycle 5: kill, fail, no relaunch.
    g0 = go_cyc; k0 = kill_cyc; b0 = busy_cyc;
    expect_result(1'b0, 2'd0);
    launch();
    tick(5);
    abort_req = 1'b1;
    tick(1);
    abort_req = 1'b0;
    wait_idle("abort", 50);
    chk("abort_go", go_cyc - g0, 1);
    chk("abort_kill", kill_cyc - k0, 2);
    chk("abort_busy_cycles", busy_cyc - b0, 1 + 6 + 2);
    chk("abort_attempt", int'(attempt), 0);

    // done_in and abort_req together; start pulses while busy are dropped.
    g0 = go_cyc; k0 = kill_cyc;
    expect_result(1'b1, 2'd0);
    launch();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    done_in = 1'b1;
    abort_req = 1'b1;
    tick(1);
    done_in = 1'b0;
    abort_req = 1'b0;
    wait_idle("both", 50);
    chk("both_go", go_cyc - g0, 1);
    chk("both_kill", kill_cyc - k0, 0);

    // done_in and abort_req in IDLE are ignored.
    b0 = busy_cyc;
    done_in = 1'b1;
    abort_req = 1'b1;
    tick(2);
    done_in = 1'b0;
    abort_req = 1'b0;
    tick(2);
    chk("idle_ignore_busy", busy_cyc - b0, 0);

    // Reset during the first kill cycle.
    launch();
    n = 0;
    @(negedge clk);
    while (!kill && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach_kill", int'(kill), 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_kill", int'(kill), 0);
    chk("rst_mid_go", int'(go), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_fail", int'(run_fail), 0);
    chk("rst_mid_attempt", int'(attempt), 0);
    tick(2);
    reset = 1'b0;
    tick(1);
    g0 = go_cyc;
    ok_run(2);
    wait_idle("post_rst", 50);
    chk("post_rst_go", go_cyc - g0, 1);

    // Statistics: 3 ok (one above), 1 fail, then saturation at 260 ok.
    ok_run(0);
    ok_run(1);
    wait_idle("stats_ok", 50);
    expect_result(1'b0, 2'd1);
    launch();
    wait_idle("stats_fail", 100);
`ifdef RUN_CTRL_STATS_EN
    exp_ok = 3; exp_fail = 1;
`else
    exp_ok = 0; exp_fail = 0;
`endif
    chk("ok_count_3", int'(ok_count), exp_ok);
    chk("fail_count_1", int'(fail_count), exp_fail);
    for (int i = 0; i < 257; i++) ok_run(0);
    wait_idle("sat", 50);
`ifdef RUN_CTRL_STATS_EN
    exp_ok = 255;
`else
    exp_ok = 0;
`endif
    chk("ok_count_sat", int'(ok_count), exp_ok);
    chk("fail_count_hold", int'(fail_count), exp_fail);

    tick(3);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
